cla_add_scheduler: RTL and testbench
====================================

// Module: cla_add_scheduler
// PURPOSE
//  Round-robin scheduler that shares one external 8-bit carry_lookahead_adder_8bit (no carry-in, 9-bit result)
//  among NUM_REQ requesters performing NUM_BYTES*8-bit additions.
//  Operations run byte-serially, low byte first. A carry into a byte is applied by a second adder pass (+1).
//  Sits between requester ports and the adder instance; the enclosing top wires o_add1/o_add2/i_result to the adder.
// PARAMETERS
//  NUM_REQ    4  number of requesters (>=2)
//  NUM_BYTES  4  operand width in bytes; W = 8*NUM_BYTES
// PORTS
//  i_clk          in   1            clock, all state on rising edge
//  i_rst_n        in   1            asynchronous active-low reset
//  i_req_valid    in   NUM_REQ      per-requester request valid
//  o_req_ready    out  NUM_REQ      one-hot grant/accept strobe
//  i_req_a        in   NUM_REQ*W    operand A, requester r at [r*W +: W]
//  i_req_b        in   NUM_REQ*W    operand B, same packing
//  i_req_sub      in   NUM_REQ      1 = A-B (only with CLA_SCHED_SUB_EN)
//  o_add1         out  8            adder input 1
//  o_add2         out  8            adder input 2
//  i_result       in   9            adder result, combinational same cycle
//  o_rsp_valid    out  1            response valid
//  i_rsp_ready    in   1            response accept
//  o_rsp_id       out  $clog2(NUM_REQ)  requester index of response
//  o_rsp_sum      out  W            sum modulo 2^W
//  o_rsp_carry    out  1            carry out of MSB (sub: 1 = no borrow)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, o_req_ready 0, o_rsp_valid 0, o_rsp_id/sum/carry 0, o_add1/o_add2 0. Async assert, sync release.
//  Reset mid-operation: operation and pending response are discarded; no response is issued.
//  IDLE: grant = first valid index scanning from ptr upward, wrapping. o_req_ready[grant] = 1 combinationally in IDLE only.
//    On accept: latch A, B (B inverted if sub), id. Set c = sub. Set byte idx = 0. Set ptr = (grant+1) mod NUM_REQ. Next state ADD.
//    When no request is valid: state stays IDLE, ptr unchanged.
//  ADD: o_add1 = A[idx], o_add2 = B[idx].
//    If c == 0: sum[idx] = i_result[7:0]; c = i_result[8]; advance.
//    If c == 1: tmp = i_result[7:0]; c1 = i_result[8]; next state INC.
//  INC: o_add1 = tmp, o_add2 = 8'h01; sum[idx] = i_result[7:0]; c = c1 | i_result[8]; advance.
//  advance: if idx == NUM_BYTES-1 go to RESP, else idx++ and go to ADD.
//  Per byte: 1 cycle with no carry-in, 2 cycles with carry-in. Total latency from accept: NUM_BYTES..2*NUM_BYTES cycles, then RESP.
//  RESP: o_rsp_valid = 1; id/sum/carry are held stable until i_rsp_ready. On handshake go to IDLE.
//    The next grant can occur in the first IDLE cycle after the handshake. No grant is issued while busy.
//  o_add1/o_add2 = 0 outside ADD/INC. Requesters hold valid and operands until ready; the scheduler never withdraws ready.
// CONFIGURATION
//  CLA_SCHED_SUB_EN defined: i_req_sub selects A + ~B + 1 (initial c = 1), so byte 0 always takes an INC pass.
//  Undefined: i_req_sub is ignored; every op is an add and c starts at 0. Ports are unchanged in both builds.
// STRUCTURE
//  Package cla_sched_pkg: state enum {IDLE, ADD, INC, RESP}; ADD_W = 8; localparam helpers for the id width.
//  Sub-module cla_rr_arbiter: NUM_REQ-wide rotating-priority arbiter (req, ptr -> one-hot grant, grant index).
//  The adder is not instantiated here.
// TESTING
//  1 NUM_BYTES=4: req0 A=0x000000FF, B=0x00000001
//    -> sum 0x00000100, carry 0, id 0; 5 compute cycles (ADD, ADD, INC, ADD, ADD).
//  2 A=0xFFFFFFFF, B=0x00000001 -> sum 0x00000000, carry 1; 7 compute cycles; o_add2=01 in every INC.
//  3 req0 and req2 valid together, ptr=0 -> req0 served then req2.
//    Then req0, req1, req2 all valid -> order 1 is not skipped: ptr=3 wraps so order is 0,1,2.
//    No requester granted twice while another waits.
//  4 i_rsp_ready low 3 cycles in RESP -> rsp fields stable, o_req_ready stays 0. Grant follows the cycle after ready.
//  5 CLA_SCHED_SUB_EN: A=5, B=3, sub=1 -> sum 2, carry 1. A=3, B=5 -> sum 0xFFFFFFFE, carry 0.
//    Without the macro, the same stimulus gives sum 8 (A=5, B=3).
//  6 i_rst_n pulsed low during INC -> all outputs 0 immediately, no response afterwards, ptr 0, next request served normally.

Source files
------------

// File: rtl/cla_sched_pkg.sv
// ---------------------------------------------------------------------------
// cla_sched_pkg
// Shared types and helpers for the byte-serial carry-lookahead adder
// scheduler.
//   state_t : scheduler FSM states
//   ADD_W   : width of the shared external adder operands
//   idx_w() : index width for a count of items, never below 1 bit
// ---------------------------------------------------------------------------
package cla_sched_pkg;

    localparam int ADD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cla_rr_arbiter
// Rotating-priority arbiter. The search starts at i_ptr and wraps, so the
// requester at i_ptr has the highest priority this cycle.
// Ports:
//   i_req        : per-requester request bits
//   i_ptr        : index with the highest priority
//   o_grant      : one-hot grant (all zero when nothing requests)
//   o_grant_idx  : binary index of the granted requester
//   o_any        : at least one request present
// ---------------------------------------------------------------------------
module cla_rr_arbiter
    import cla_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_grant_idx,
    output logic               o_any
);

    logic [IDW-1:0] w_k;
    logic           w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_k         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = IDW'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_grant_idx  = w_k;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/cla_add_scheduler.sv
// ---------------------------------------------------------------------------
// cla_add_scheduler
// Shares one external 8-bit carry-lookahead adder (no carry-in, 9-bit
// result) among NUM_REQ requesters doing NUM_BYTES*8-bit additions. Work is
// byte-serial, low byte first; a carry into a byte costs a second adder pass
// that adds 1 to the partial byte.
//
// Build option: define CLA_SCHED_SUB_EN to honour i_req_sub (A + ~B + 1).
// Without it i_req_sub is ignored and every operation is an add.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset (sync release)
//   i_req_valid/o_req_ready   per-requester request / one-hot accept
//   i_req_a, i_req_b          operands, requester r at [r*W +: W]
//   i_req_sub                 per-requester subtract select
//   o_add1, o_add2, i_result  connection to the external adder
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_id/sum/carry        response payload
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate, accept one request
// ADD   | A byte + B byte; carry pending sends the byte through INC
// INC   | partial byte + 1 to absorb the incoming carry
// RESP  | hold response until i_rsp_ready
// ---------------------------------------------------------------------------
module cla_add_scheduler
    import cla_sched_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int NUM_BYTES = 4,
    localparam int W         = 8 * NUM_BYTES,
    localparam int IDW       = idx_w(NUM_REQ),
    localparam int BIW       = idx_w(NUM_BYTES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [NUM_REQ*W-1:0] i_req_a,
    input  logic [NUM_REQ*W-1:0] i_req_b,
    input  logic [NUM_REQ-1:0]   i_req_sub,
    output logic [ADD_W-1:0]     o_add1,
    output logic [ADD_W-1:0]     o_add2,
    input  logic [ADD_W:0]       i_result,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [W-1:0]         o_rsp_sum,
    output logic                 o_rsp_carry
);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [BIW-1:0]     r_idx;
    logic               r_c;
    logic               r_c1;
    logic [ADD_W-1:0]   r_tmp;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_any;
    logic               w_accept;
    logic               w_sub;
    logic               w_last;
    logic [W-1:0]       w_sel_a;
    logic [W-1:0]       w_sel_b;
    logic [ADD_W-1:0]   w_a_byte;
    logic [ADD_W-1:0]   w_b_byte;
    logic [IDW-1:0]     w_ptr_nxt;

    // Reset asserts asynchronously through the synchroniser flops and
    // releases two clocks later, aligned to i_clk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    cla_rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_arb (
        .i_req       (i_req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_accept  = (r_state == IDLE) && w_any && w_rst_n;
    assign w_sel_a   = i_req_a[w_grant_idx*W +: W];
    assign w_sel_b   = i_req_b[w_grant_idx*W +: W];
    assign w_ptr_nxt = (w_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDW'(1);
    assign w_last    = (r_idx == BIW'(NUM_BYTES - 1));
    assign w_a_byte  = r_a[{r_idx, 3'b000} +: ADD_W];
    assign w_b_byte  = r_b[{r_idx, 3'b000} +: ADD_W];

`ifdef CLA_SCHED_SUB_EN
    assign w_sub = i_req_sub[w_grant_idx];
`else
    // Port kept for a uniform interface; its value has no effect here.
    logic w_unused_sub;
    assign w_unused_sub = ^i_req_sub;
    assign w_sub        = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                if (r_c) begin
                    w_state_nxt = INC;
                end else if (w_last) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = ADD;
                end
            end
            INC: begin
                w_state_nxt = w_last ? RESP : ADD;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs; ready is masked while the reset synchroniser is still low so
    // no grant leaks out during reset.
    always_comb begin
        o_req_ready = '0;
        o_add1      = '0;
        o_add2      = '0;
        case (r_state)
            IDLE: begin
                if (w_rst_n) begin
                    o_req_ready = w_grant;
                end
            end
            ADD: begin
                o_add1 = w_a_byte;
                o_add2 = w_b_byte;
            end
            INC: begin
                o_add1 = r_tmp;
                o_add2 = 8'h01;
            end
            default: ;
        endcase
    end

    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_id    = r_id;
    assign o_rsp_sum   = r_sum;
    assign o_rsp_carry = r_c;

    // Datapath. r_c doubles as the running carry and, in RESP, the final
    // carry out of the MSB.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_idx <= '0;
            r_c   <= 1'b0;
            r_c1  <= 1'b0;
            r_tmp <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= w_sel_a;
                        r_b   <= w_sub ? ~w_sel_b : w_sel_b;
                        r_id  <= w_grant_idx;
                        r_c   <= w_sub;
                        r_idx <= '0;
                        r_ptr <= w_ptr_nxt;
                    end
                end
                ADD: begin
                    if (!r_c) begin
                        r_sum[{r_idx, 3'b000} +: ADD_W] <= i_result[ADD_W-1:0];
                        r_c                             <= i_result[ADD_W];
                        if (!w_last) begin
                            r_idx <= r_idx + BIW'(1);
                        end
                    end else begin
                        r_tmp <= i_result[ADD_W-1:0];
                        r_c1  <= i_result[ADD_W];
                    end
                end
                INC: begin
                    r_sum[{r_idx, 3'b000} +: ADD_W] <= i_result[ADD_W-1:0];
                    r_c                             <= r_c1 | i_result[ADD_W];
                    if (!w_last) begin
                        r_idx <= r_idx + BIW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_add_scheduler.sv
module tb_cla_add_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int NUM_BYTES = 4;
    localparam int W         = 8 * NUM_BYTES;
    localparam int IDW       = 2;

    logic                 i_clk       = 1'b0;
    logic                 i_rst_n     = 1'b0;
    logic [NUM_REQ-1:0]   i_req_valid = '0;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [NUM_REQ*W-1:0] i_req_a     = '0;
    logic [NUM_REQ*W-1:0] i_req_b     = '0;
    logic [NUM_REQ-1:0]   i_req_sub   = '0;
    logic [7:0]           o_add1;
    logic [7:0]           o_add2;
    logic [8:0]           i_result;
    logic                 o_rsp_valid;
    logic                 i_rsp_ready = 1'b0;
    logic [IDW-1:0]       o_rsp_id;
    logic [W-1:0]         o_rsp_sum;
    logic                 o_rsp_carry;

    cla_add_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .NUM_BYTES   (NUM_BYTES)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_sub   (i_req_sub),
        .o_add1      (o_add1),
        .o_add2      (o_add2),
        .i_result    (i_result),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_sum   (o_rsp_sum),
        .o_rsp_carry (o_rsp_carry)
    );

    // external 8-bit adder, no carry-in
    assign i_result = {1'b0, o_add1} + {1'b0, o_add2};

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         id;
        logic [W-1:0] sum;
        logic       carry;
        int         lat;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        obs_q[$];
    int          grant_q[$];
    logic [15:0] trace_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    // Whole-word reference: sum/carry from one wide add, latency from the
    // carry into each byte boundary.
    function automatic rsp_t model(input int r, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input bit sub);
        rsp_t       m;
        logic [W:0] full;
        logic [W:0] low;
        logic [W:0] mask;
        logic [W-1:0] bb;
        bit         c0;
`ifdef CLA_SCHED_SUB_EN
        c0 = sub;
`else
        c0 = 1'b0;
`endif
        bb     = c0 ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        m.id    = r;
        m.sum   = full[W-1:0];
        m.carry = full[W];
        m.lat   = NUM_BYTES + int'(c0);
        for (int k = 1; k < NUM_BYTES; k++) begin
            mask = ((W+1)'(1) << (8 * k)) - (W+1)'(1);
            low  = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + {{W{1'b0}}, c0};
            if (low[8*k]) m.lat++;
        end
        return m;
    endfunction

    task automatic post(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        i_req_a[r*W +: W] = a;
        i_req_b[r*W +: W] = b;
        i_req_sub[r]      = sub;
        i_req_valid[r]    = 1'b1;
    endtask

    task automatic do_reset();
        i_req_valid = '0;
        i_rst_n     = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n     = 1'b1;
        repeat (3) @(negedge i_clk);
        exp_q.delete();
        obs_q.delete();
        grant_q.delete();
    endtask

    // Requester/responder engine: called at a negedge, keeps i_rsp_ready high,
    // pushes the model result at each grant, records responses.
    task automatic run(input int n_rsp, input int max_cyc, output bit timeout);
        int   got;
        int   cyc;
        int   lat;
        int   drop;
        int   gr;
        bit   busy;
        rsp_t o;
        got = 0; cyc = 0; lat = 0; drop = -1; busy = 1'b0; gr = 0;
        timeout     = 1'b0;
        i_rsp_ready = 1'b1;
        while (got < n_rsp) begin
            if (drop >= 0) begin
                i_req_valid[drop] = 1'b0;
                drop = -1;
            end
            #1;
            if (busy) begin
                if (o_rsp_valid) begin
                    o.id = int'(o_rsp_id); o.sum = o_rsp_sum; o.carry = o_rsp_carry; o.lat = lat;
                    obs_q.push_back(o);
                    got++;
                    busy = 1'b0;
                end else begin
                    lat++;
                    trace_q.push_back({o_add1, o_add2});
                end
            end else if (|o_req_ready) begin
                for (int r = 0; r < NUM_REQ; r++) if (o_req_ready[r]) gr = r;
                exp_q.push_back(model(gr, i_req_a[gr*W +: W], i_req_b[gr*W +: W], i_req_sub[gr]));
                grant_q.push_back(gr);
                drop = gr; busy = 1'b1; lat = 0;
                trace_q.delete();
            end
            cyc++;
            if (cyc > max_cyc) begin
                timeout = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_reset();
        i_req_valid[0] = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        n_total++;
        if (o_req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", o_req_ready);
        else n_pass++;
        n_total++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_carry, o_add1, o_add2} !== '0)
            $display("FAIL reset_outputs: got valid=%b id=%0d sum=%h c=%b add1=%h add2=%h want all 0",
                     o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_carry, o_add1, o_add2);
        else n_pass++;
        i_req_valid = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        #1;
        n_total++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== '0)
            $display("FAIL reset_idle: got valid=%b ready=%b want 0 0000", o_rsp_valid, o_req_ready);
        else n_pass++;
        @(negedge i_clk);
    endtask

    task automatic test_add_carry();
        bit          to;
        bit          ok;
        rsp_t        e;
        rsp_t        o;
        logic [15:0] tr1 [5];
        logic [15:0] tr2 [7];
        tr1 = '{16'hFF01, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
        tr2 = '{16'hFF01, 16'hFF00, 16'hFF01, 16'hFF00, 16'hFF01, 16'hFF00, 16'hFF01};

        post(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        run(1, 100, to);
        n_total++;
        if (to || obs_q.size() != 1) $display("FAIL t1_resp_count: timeout=%0b got %0d want 1", to, obs_q.size());
        else n_pass++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.id !== e.id || o.sum !== e.sum || o.carry !== e.carry || e.sum !== 32'h100)
                $display("FAIL t1_rsp: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                         o.id, o.sum, o.carry, e.id, e.sum, e.carry);
            else n_pass++;
            n_total++;
            if (o.lat != 5) $display("FAIL t1_latency: got %0d want 5", o.lat);
            else n_pass++;
        end
        ok = (trace_q.size() == 5);
        for (int i = 0; i < 5; i++) if (i < trace_q.size() && trace_q[i] !== tr1[i]) ok = 1'b0;
        n_total++;
        if (!ok) $display("FAIL t1_trace: got %p want %p", trace_q, tr1);
        else n_pass++;

        post(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run(1, 100, to);
        n_total++;
        if (to || obs_q.size() != 1) $display("FAIL t2_resp_count: timeout=%0b got %0d want 1", to, obs_q.size());
        else n_pass++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.id !== e.id || o.sum !== e.sum || o.carry !== e.carry || e.carry !== 1'b1)
                $display("FAIL t2_rsp: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                         o.id, o.sum, o.carry, e.id, e.sum, e.carry);
            else n_pass++;
            n_total++;
            if (o.lat != e.lat || o.lat != 7) $display("FAIL t2_latency: got %0d want 7", o.lat);
            else n_pass++;
        end
        ok = (trace_q.size() == 7);
        for (int i = 0; i < 7; i++) if (i < trace_q.size() && trace_q[i] !== tr2[i]) ok = 1'b0;
        n_total++;
        if (!ok) $display("FAIL t2_trace: got %p want %p", trace_q, tr2);
        else n_pass++;
    endtask

    task automatic test_rr();
        bit   to;
        rsp_t e;
        rsp_t o;
        do_reset();
        post(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        post(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run(2, 200, to);
        n_total++;
        if (to || grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 2)
            $display("FAIL rr_pair_order: timeout=%0b got %p want 0 then 2", to, grant_q);
        else n_pass++;
        grant_q.delete();
        post(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0);
        post(1, 32'hDEAD_BEEF, 32'h0102_0304, 1'b0);
        post(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run(3, 300, to);
        n_total++;
        if (to || grant_q.size() != 3 || grant_q[0] != 0 || grant_q[1] != 1 || grant_q[2] != 2)
            $display("FAIL rr_wrap_order: timeout=%0b got %p want 0 1 2", to, grant_q);
        else n_pass++;
        n_total++;
        if (obs_q.size() != 5 || exp_q.size() != 5)
            $display("FAIL rr_rsp_count: got %0d want 5", obs_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.id !== e.id || o.sum !== e.sum || o.carry !== e.carry || o.lat != e.lat)
                $display("FAIL rr_rsp: got id=%0d sum=%h c=%b lat=%0d want id=%0d sum=%h c=%b lat=%0d",
                         o.id, o.sum, o.carry, o.lat, e.id, e.sum, e.carry, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit             to;
        bit             stable;
        bit             quiet;
        int             cyc;
        int             gr;
        rsp_t           e;
        rsp_t           o;
        logic [IDW-1:0] cap_id;
        logic [W-1:0]   cap_sum;
        logic           cap_c;
        i_rsp_ready = 1'b0;
        post(1, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
        post(3, 32'hAAAA_AAAA, 32'h5555_5556, 1'b0);
        cyc = 0;
        #1;
        while (o_req_ready == '0 && cyc < 20) begin
            @(negedge i_clk); #1; cyc++;
        end
        n_total++;
        if (o_req_ready !== 4'b1000) $display("FAIL bp_first_grant: got %b want 1000", o_req_ready);
        else n_pass++;
        gr = 3;
        for (int r = 0; r < NUM_REQ; r++) if (o_req_ready[r]) gr = r;
        exp_q.push_back(model(gr, i_req_a[gr*W +: W], i_req_b[gr*W +: W], i_req_sub[gr]));
        @(negedge i_clk);
        i_req_valid[gr] = 1'b0;
        cyc = 0;
        #1;
        while (!o_rsp_valid && cyc < 40) begin
            @(negedge i_clk); #1; cyc++;
        end
        n_total++;
        if (o_rsp_valid !== 1'b1) $display("FAIL bp_rsp_timeout: got valid=%b want 1", o_rsp_valid);
        else n_pass++;
        cap_id = o_rsp_id; cap_sum = o_rsp_sum; cap_c = o_rsp_carry;
        stable = 1'b1; quiet = 1'b1;
        repeat (3) begin
            @(negedge i_clk); #1;
            if (!o_rsp_valid || o_rsp_id !== cap_id || o_rsp_sum !== cap_sum || o_rsp_carry !== cap_c)
                stable = 1'b0;
            if (o_req_ready !== '0) quiet = 1'b0;
        end
        n_total++;
        if (!stable) $display("FAIL bp_hold: got valid=%b id=%0d sum=%h c=%b want held id=%0d sum=%h c=%b",
                              o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_carry, cap_id, cap_sum, cap_c);
        else n_pass++;
        n_total++;
        if (!quiet) $display("FAIL bp_no_grant_busy: got ready=%b while stalled want 0000", o_req_ready);
        else n_pass++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (int'(cap_id) != e.id || cap_sum !== e.sum || cap_c !== e.carry)
                $display("FAIL bp_rsp: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                         cap_id, cap_sum, cap_c, e.id, e.sum, e.carry);
            else n_pass++;
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk); #1;
        n_total++;
        if (o_req_ready !== 4'b0010 || o_rsp_valid !== 1'b0)
            $display("FAIL bp_next_grant: got ready=%b valid=%b want 0010 0", o_req_ready, o_rsp_valid);
        else n_pass++;
        grant_q.delete();
        run(1, 100, to);
        n_total++;
        if (to || obs_q.size() != 1 || exp_q.size() != 1)
            $display("FAIL bp_second_count: timeout=%0b got %0d want 1", to, obs_q.size());
        else n_pass++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.id !== 1 || o.id !== e.id || o.sum !== e.sum || o.carry !== e.carry)
                $display("FAIL bp_second_rsp: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                         o.id, o.sum, o.carry, e.id, e.sum, e.carry);
            else n_pass++;
        end
    endtask

    task automatic test_sub();
        bit   to;
        rsp_t e;
        rsp_t o;
        logic [W-1:0] want_sum0;
        logic         want_c0;
`ifdef CLA_SCHED_SUB_EN
        want_sum0 = 32'h2; want_c0 = 1'b1;
`else
        want_sum0 = 32'h8; want_c0 = 1'b0;
`endif
        post(0, 32'd5, 32'd3, 1'b1);
        run(1, 100, to);
        post(0, 32'd3, 32'd5, 1'b1);
        run(1, 100, to);
        post(0, 32'd5, 32'd3, 1'b0);
        run(1, 100, to);
        n_total++;
        if (to || obs_q.size() != 3 || exp_q.size() != 3)
            $display("FAIL sub_count: timeout=%0b got %0d want 3", to, obs_q.size());
        else n_pass++;
        if (obs_q.size() > 0) begin
            n_total++;
            if (obs_q[0].sum !== want_sum0 || obs_q[0].carry !== want_c0)
                $display("FAIL sub_5_3: got sum=%h c=%b want sum=%h c=%b",
                         obs_q[0].sum, obs_q[0].carry, want_sum0, want_c0);
            else n_pass++;
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.id !== e.id || o.sum !== e.sum || o.carry !== e.carry || o.lat != e.lat)
                $display("FAIL sub_rsp: got id=%0d sum=%h c=%b lat=%0d want id=%0d sum=%h c=%b lat=%0d",
                         o.id, o.sum, o.carry, o.lat, e.id, e.sum, e.carry, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit   to;
        bit   seen;
        int   cyc;
        rsp_t e;
        rsp_t o;
        post(2, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        cyc = 0;
        #1;
        while (o_req_ready == '0 && cyc < 20) begin
            @(negedge i_clk); #1; cyc++;
        end
        @(negedge i_clk);
        i_req_valid[2] = 1'b0;
        cyc = 0;
        #1;
        while (!(o_add1 == 8'h00 && o_add2 == 8'h01) && cyc < 20) begin
            @(negedge i_clk); #1; cyc++;
        end
        n_total++;
        if (cyc >= 20) $display("FAIL rst_find_inc: got no INC pass in %0d cycles want one", cyc);
        else n_pass++;
        i_rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_carry, o_add1, o_add2} !== '0)
            $display("FAIL rst_mid_outputs: got ready=%b valid=%b id=%0d sum=%h c=%b add1=%h add2=%h want all 0",
                     o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_carry, o_add1, o_add2);
        else n_pass++;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge i_clk); #1;
            if (o_rsp_valid) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL rst_no_rsp: got rsp_valid=1 after reset want 0");
        else n_pass++;
        @(negedge i_clk);
        grant_q.delete(); exp_q.delete(); obs_q.delete();
        post(1, 32'h0000_1234, 32'h0000_4321, 1'b0);
        post(3, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
        run(2, 200, to);
        n_total++;
        if (to || grant_q.size() != 2 || grant_q[0] != 1 || grant_q[1] != 3)
            $display("FAIL rst_ptr_order: timeout=%0b got %p want 1 then 3", to, grant_q);
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.id !== e.id || o.sum !== e.sum || o.carry !== e.carry || o.lat != e.lat)
                $display("FAIL rst_after_rsp: got id=%0d sum=%h c=%b lat=%0d want id=%0d sum=%h c=%b lat=%0d",
                         o.id, o.sum, o.carry, o.lat, e.id, e.sum, e.carry, e.lat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_rr();
        test_backpressure();
        test_sub();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
